// File: rtl/opl3_i2s_tx_if.sv
// Sample stream handoff from the channel/DAC-prep stage into the I2S serializer.
// The producer drives a one-cycle strobe together with a stereo pair.
interface opl3_i2s_tx_if #(
  parameter int SAMPLE_WIDTH = 24
) ();

  logic                           sample_valid;
  logic signed [SAMPLE_WIDTH-1:0] sample_l;
  logic signed [SAMPLE_WIDTH-1:0] sample_r;

  modport master (
    output sample_valid,
    output sample_l,
    output sample_r
  );

  modport slave (
    input sample_valid,
    input sample_l,
    input sample_r
  );

endinterface

// File: rtl/opl3_i2s_tx.sv
// Philips-format I2S transmitter for the OPL3 output path.
// Divides clk down to a bit clock and holds one pending stereo pair.
// At every frame boundary the pair moves into the transmit registers,
// and the frame is shifted out MSB first, one bclk after each lrclk edge.
// If no new pair has arrived, the previous frame is repeated and an
// underrun pulse is raised. A pair that replaces one still waiting to be
// sent raises an overrun pulse.
module opl3_i2s_tx #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_WIDTH   = 32,
  parameter int BCLK_DIV     = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  opl3_i2s_tx_if.slave       smp,
  output logic               i2s_bclk,
  output logic               i2s_lrclk,
  output logic               i2s_sdata,
  output logic               underrun,
  output logic               overrun
);

  localparam int FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_BITS = BIT_W'(SLOT_WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0]               div_cnt;
  logic [BIT_W-1:0]               bit_cnt;
  logic signed [SAMPLE_WIDTH-1:0] pend_l;
  logic signed [SAMPLE_WIDTH-1:0] pend_r;
  logic                           pend_full;
  logic signed [SAMPLE_WIDTH-1:0] tx_l;
  logic signed [SAMPLE_WIDTH-1:0] tx_r;

  logic             div_tick;
  logic             fall;
  logic             load;
  logic [BIT_W-1:0] bit_next;
  logic             right_next;
  logic [BIT_W-1:0] k_next;
  logic             sdata_next;

  // Decode divider/bit events and work out the serial bit for the next bclk period.
  always_comb begin
    div_tick   = (div_cnt == DIV_LAST);
    fall       = div_tick && i2s_bclk;
    load       = fall && (bit_cnt == BIT_LAST);
    bit_next   = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
    right_next = (bit_next >= SLOT_BITS);
    k_next     = right_next ? (bit_next - SLOT_BITS) : bit_next;
    sdata_next = 1'b0;
    for (int i = 0; i < SAMPLE_WIDTH; i++) begin
      if (k_next == BIT_W'(SAMPLE_WIDTH - i)) begin
        sdata_next = right_next ? tx_r[i] : tx_l[i];
      end
    end
  end

  // Clock divider: bclk toggles each time the counter reaches its terminal count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt  <= '0;
      i2s_bclk <= 1'b0;
    end else if (div_tick) begin
      div_cnt  <= '0;
      i2s_bclk <= ~i2s_bclk;
    end else begin
      div_cnt  <= div_cnt + DIV_W'(1);
    end
  end

  // Frame position and serial outputs advance only as bclk falls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt   <= BIT_LAST;
      i2s_lrclk <= 1'b0;
      i2s_sdata <= 1'b0;
    end else if (fall) begin
      bit_cnt   <= bit_next;
      i2s_lrclk <= right_next;
      i2s_sdata <= sdata_next;
    end
  end

  // Pending buffer, frame load into the transmit words, and status pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_l    <= '0;
      pend_r    <= '0;
      pend_full <= 1'b0;
      tx_l      <= '0;
      tx_r      <= '0;
      underrun  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      underrun <= load && !pend_full;
      overrun  <= smp.sample_valid && pend_full && !load;
      if (load && pend_full) begin
        tx_l <= pend_l;
        tx_r <= pend_r;
      end
      if (smp.sample_valid) begin
        pend_l    <= smp.sample_l;
        pend_r    <= smp.sample_r;
        pend_full <= 1'b1;
      end else if (load) begin
        pend_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_opl3_i2s_tx.sv
// Self-checking bench for opl3_i2s_tx with BCLK_DIV=2, SLOT_WIDTH=32, SAMPLE_WIDTH=24.
// A time-indexed reference model predicts every output from the number of
// clk edges since reset release; directed frames are also pinned to literals.
module tb_opl3_i2s_tx;

  localparam int SW      = 24;
  localparam int SLOT    = 32;
  localparam int DIV     = 2;
  localparam int BCLK_P  = 2 * DIV;
  localparam int FRAME_C = 4 * SLOT * DIV;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic i2s_bclk, i2s_lrclk, i2s_sdata, underrun, overrun;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  opl3_i2s_tx_if #(.SAMPLE_WIDTH(SW)) smp ();

  opl3_i2s_tx #(
    .SAMPLE_WIDTH(SW),
    .SLOT_WIDTH  (SLOT),
    .BCLK_DIV    (DIV)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .smp      (smp),
    .i2s_bclk (i2s_bclk),
    .i2s_lrclk(i2s_lrclk),
    .i2s_sdata(i2s_sdata),
    .underrun (underrun),
    .overrun  (overrun)
  );

  // Reference model: n = clk edges since reset release, plus the sample buffer.
  int          n;
  bit          m_pend_full;
  logic [23:0] m_pend_l, m_pend_r, m_tx_l, m_tx_r;
  bit          m_ur, m_or;

  always @(posedge clk or negedge reset_n) begin
    bit is_load;
    if (!reset_n) begin
      n = 0;
      m_pend_full = 1'b0;
      m_pend_l = '0; m_pend_r = '0;
      m_tx_l = '0; m_tx_r = '0;
      m_ur = 1'b0; m_or = 1'b0;
    end else begin
      n = n + 1;
      is_load = (n % BCLK_P == 0) && (((n / BCLK_P) - 1) % (2 * SLOT) == 0);
      m_ur = is_load && !m_pend_full;
      m_or = smp.sample_valid && m_pend_full && !is_load;
      if (is_load && m_pend_full) begin
        m_tx_l = m_pend_l;
        m_tx_r = m_pend_r;
        m_pend_full = 1'b0;
      end
      if (smp.sample_valid) begin
        m_pend_l = smp.sample_l;
        m_pend_r = smp.sample_r;
        m_pend_full = 1'b1;
      end
    end
  end

  function automatic logic exp_bclk(input int nn);
    return ((nn / DIV) % 2) == 1;
  endfunction

  function automatic logic exp_lr(input int nn);
    int b;
    if (nn < BCLK_P) return 1'b0;
    b = ((nn / BCLK_P) - 1) % (2 * SLOT);
    return b >= SLOT;
  endfunction

  function automatic logic exp_sd(input int nn, input logic [23:0] wl, input logic [23:0] wr);
    int b, k;
    if (nn < BCLK_P) return 1'b0;
    b = ((nn / BCLK_P) - 1) % (2 * SLOT);
    k = b % SLOT;
    if (k < 1 || k > SW) return 1'b0;
    return (b >= SLOT) ? wr[SW - k] : wl[SW - k];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (t=%0t n=%0d)", name, actual, expected, $time, n);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("bclk",     64'(i2s_bclk),  64'(exp_bclk(n)));
      checkOutput("lrclk",    64'(i2s_lrclk), 64'(exp_lr(n)));
      checkOutput("sdata",    64'(i2s_sdata), 64'(exp_sd(n, m_tx_l, m_tx_r)));
      checkOutput("underrun", 64'(underrun),  64'(m_ur));
      checkOutput("overrun",  64'(overrun),   64'(m_or));
    end
  end

  // Flag pulse bookkeeping taken straight from the DUT outputs.
  int ur_count = 0, or_count = 0, last_ur_n = -1, last_or_n = -1;
  always @(negedge clk) begin
    if (underrun) begin ur_count++; last_ur_n = n; end
    if (overrun)  begin or_count++; last_or_n = n; end
  end

  task automatic waitN(input int target);
    int guard = 0;
    while (n != target && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (n != target) checkOutput("wait_timeout", 64'(n), 64'(target));
  endtask

  // Pulse sample_valid for one cycle starting at the current negedge.
  task automatic applyStimulus(input logic [23:0] l, input logic [23:0] r);
    smp.sample_valid = 1'b1;
    smp.sample_l = l;
    smp.sample_r = r;
    @(negedge clk);
    smp.sample_valid = 1'b0;
  endtask

  // Sample sdata/lrclk at each bclk rise of frame j (index = bit position in frame).
  task automatic captureFrame(input int j, output logic [63:0] sd, output logic [63:0] lr);
    sd = '0;
    lr = '0;
    for (int b = 0; b < 2 * SLOT; b++) begin
      waitN(FRAME_C * j + BCLK_P + DIV + BCLK_P * b);
      sd[b] = i2s_sdata;
      lr[b] = i2s_lrclk;
    end
  endtask

  function automatic logic [23:0] wordOf(input logic [63:0] sd, input bit right);
    logic [23:0] w;
    for (int k = 1; k <= SW; k++) w[SW - k] = sd[(right ? SLOT : 0) + k];
    return w;
  endfunction

  logic [63:0] fsd, flr;

  initial begin
    smp.sample_valid = 1'b0;
    smp.sample_l = '0;
    smp.sample_r = '0;
    #1 reset_n = 1'b0;
    #1 cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_bclk",  64'(i2s_bclk),  64'd0);
    checkOutput("reset_lrclk", 64'(i2s_lrclk), 64'd0);
    checkOutput("reset_sdata", 64'(i2s_sdata), 64'd0);
    reset_n = 1'b1;

    // Basic frame, sample arrives before the first fall event.
    applyStimulus(24'h800001, 24'h7FFFFE);
    captureFrame(0, fsd, flr);
    checkOutput("basic_left_bits",  64'(fsd[31:0]),  64'h01000002);
    checkOutput("basic_right_bits", 64'(fsd[63:32]), 64'h00FFFFFC);
    checkOutput("basic_lrclk_bits", flr, 64'hFFFFFFFF00000000);
    checkOutput("basic_no_ur", 64'(ur_count), 64'd0);
    checkOutput("basic_no_or", 64'(or_count), 64'd0);

    // Underrun: no new pair, second frame repeats.
    captureFrame(1, fsd, flr);
    checkOutput("ur_left_bits",  64'(fsd[31:0]),  64'h01000002);
    checkOutput("ur_right_bits", 64'(fsd[63:32]), 64'h00FFFFFC);
    checkOutput("ur_count", 64'(ur_count), 64'd1);
    checkOutput("ur_when",  64'(last_ur_n), 64'd260);

    // Overrun: A then B inside frame 2, frame 3 carries B.
    waitN(540);
    applyStimulus(24'h000001, 24'h000002);
    waitN(600);
    applyStimulus(24'h123456, 24'h654321);
    captureFrame(3, fsd, flr);
    checkOutput("or_count", 64'(or_count), 64'd1);
    checkOutput("or_when",  64'(last_or_n), 64'd601);
    checkOutput("or_left",  64'(wordOf(fsd, 1'b0)), 64'h123456);
    checkOutput("or_right", 64'(wordOf(fsd, 1'b1)), 64'h654321);
    checkOutput("or_ur_count", 64'(ur_count), 64'd2);

    // Same-cycle load: A pending, B arrives exactly in the load cycle.
    applyStimulus(24'h0ABCDE, 24'h135790);
    waitN(1027);
    applyStimulus(24'h2468AC, 24'h7531F0);
    captureFrame(4, fsd, flr);
    checkOutput("same_a_left",  64'(wordOf(fsd, 1'b0)), 64'h0ABCDE);
    checkOutput("same_a_right", 64'(wordOf(fsd, 1'b1)), 64'h135790);
    captureFrame(5, fsd, flr);
    checkOutput("same_b_left",  64'(wordOf(fsd, 1'b0)), 64'h2468AC);
    checkOutput("same_b_right", 64'(wordOf(fsd, 1'b1)), 64'h7531F0);
    checkOutput("same_ur_count", 64'(ur_count), 64'd2);
    checkOutput("same_or_count", 64'(or_count), 64'd1);

    // Random sample traffic, checked cycle by cycle against the model.
    repeat (6000) begin
      @(negedge clk);
      smp.sample_valid = ($urandom_range(0, 199) == 0);
      smp.sample_l = 24'($urandom);
      smp.sample_r = 24'($urandom);
    end
    @(negedge clk);
    smp.sample_valid = 1'b0;

    // Asynchronous reset in the middle of a right slot.
    begin
      int guard = 0;
      while (!exp_lr(n) && guard < 1000) begin
        @(negedge clk);
        guard++;
      end
    end
    checkOutput("pre_reset_lrclk", 64'(i2s_lrclk), 64'd1);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("async_bclk",  64'(i2s_bclk),  64'd0);
    checkOutput("async_lrclk", 64'(i2s_lrclk), 64'd0);
    checkOutput("async_sdata", 64'(i2s_sdata), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(24'h5A5A5A, 24'hA5A5A5);
    waitN(3);
    checkOutput("rel_bclk_high", 64'(i2s_bclk), 64'd1);
    waitN(4);
    checkOutput("rel_bclk_fall", 64'(i2s_bclk), 64'd0);
    checkOutput("rel_lrclk",     64'(i2s_lrclk), 64'd0);
    captureFrame(0, fsd, flr);
    checkOutput("rel_left",  64'(wordOf(fsd, 1'b0)), 64'h5A5A5A);
    checkOutput("rel_right", 64'(wordOf(fsd, 1'b1)), 64'hA5A5A5);
    checkOutput("rel_lrclk_bits", flr, 64'hFFFFFFFF00000000);

    repeat (4) @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
